nic_access_scheduler: RTL and testbench

//  Processor-side sequencer that shares one NIC register port between two local clients.

---
 rtl/nic_access_scheduler.sv | 157 +++++++++++++++
 tb/tb_nic_access_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nic_access_scheduler.sv
// Shares one NIC register port between two local clients: polls receive
// status, drains received flits to the client picked by a header bit, and
// round-robin arbitrates the clients' send requests into the NIC output buffer.
module nic_access_scheduler #(
  parameter int DATA_WIDTH = 64,
  parameter int RX_SEL_BIT = 56
) (
  input  logic                  clk,
  input  logic                  reset,
  // client send side
  input  logic                  tx0_valid,
  input  logic [DATA_WIDTH-1:0] tx0_data,
  output logic                  tx0_ready,
  input  logic                  tx1_valid,
  input  logic [DATA_WIDTH-1:0] tx1_data,
  output logic                  tx1_ready,
  // client receive side (data shared by both clients)
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx0_valid,
  input  logic                  rx0_ready,
  output logic                  rx1_valid,
  input  logic                  rx1_ready,
  // NIC register port
  output logic                  nicEn,
  output logic                  nicWrEn,
  output logic [1:0]            nicAddr,
  output logic [DATA_WIDTH-1:0] nicDin,
  input  logic [DATA_WIDTH-1:0] nicDout
);

  localparam logic [1:0] ADDR_RX_DATA    = 2'b00;
  localparam logic [1:0] ADDR_IN_STATUS  = 2'b01;
  localparam logic [1:0] ADDR_TX_DATA    = 2'b10;
  localparam logic [1:0] ADDR_OUT_STATUS = 2'b11;

  typedef enum logic [2:0] {
    RX_POLL,
    RX_READ,
    RX_DLV,
    TX_ARB,
    TX_POLL,
    TX_WRITE
  } state_t;

  state_t                state_reg, state_next;
  logic                  rr_ptr_reg, rr_ptr_next;
  logic                  pending_reg, pending_next;
  logic                  grant_reg, grant_next;
  logic [DATA_WIDTH-1:0] rx_buf_reg, rx_buf_next;

  // State and arbitration registers; reset discards any buffered flit or pending send.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= RX_POLL;
      rr_ptr_reg  <= 1'b0;
      pending_reg <= 1'b0;
      grant_reg   <= 1'b0;
      rx_buf_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      rr_ptr_reg  <= rr_ptr_next;
      pending_reg <= pending_next;
      grant_reg   <= grant_next;
      rx_buf_reg  <= rx_buf_next;
    end
  end

  // Next-state logic and output decode; every output is forced low while reset is high.
  always_comb begin
    state_next   = state_reg;
    rr_ptr_next  = rr_ptr_reg;
    pending_next = pending_reg;
    grant_next   = grant_reg;
    rx_buf_next  = rx_buf_reg;

    nicEn     = 1'b0;
    nicWrEn   = 1'b0;
    nicAddr   = ADDR_RX_DATA;
    nicDin    = '0;
    rx_data   = rx_buf_reg;
    rx0_valid = 1'b0;
    rx1_valid = 1'b0;
    tx0_ready = 1'b0;
    tx1_ready = 1'b0;

    case (state_reg)
      RX_POLL: begin
        nicEn   = 1'b1;
        nicAddr = ADDR_IN_STATUS;
        state_next = nicDout[0] ? RX_READ : TX_ARB;
      end

      RX_READ: begin
        // The NIC clears in_status on this same edge.
        nicEn       = 1'b1;
        nicAddr     = ADDR_RX_DATA;
        rx_buf_next = nicDout;
        state_next  = RX_DLV;
      end

      RX_DLV: begin
        // Hold the flit for the addressed client only, until it accepts.
        if (rx_buf_reg[RX_SEL_BIT]) begin
          rx1_valid = 1'b1;
          if (rx1_ready) state_next = TX_ARB;
        end else begin
          rx0_valid = 1'b1;
          if (rx0_ready) state_next = TX_ARB;
        end
      end

      TX_ARB: begin
        // A grant already issued is kept even if the other client becomes valid.
        if (!pending_reg && (tx0_valid || tx1_valid)) begin
          grant_next   = (rr_ptr_reg ? tx1_valid : tx0_valid) ? rr_ptr_reg : ~rr_ptr_reg;
          pending_next = 1'b1;
        end
        state_next = pending_next ? TX_POLL : RX_POLL;
      end

      TX_POLL: begin
        // Output buffer full: go back to receive polling and retry the same grant later.
        nicEn      = 1'b1;
        nicAddr    = ADDR_OUT_STATUS;
        state_next = nicDout[0] ? RX_POLL : TX_WRITE;
      end

      TX_WRITE: begin
        // Room was seen last cycle and nothing else writes the NIC, so this write lands.
        nicEn        = 1'b1;
        nicWrEn      = 1'b1;
        nicAddr      = ADDR_TX_DATA;
        nicDin       = grant_reg ? tx1_data : tx0_data;
        tx0_ready    = ~grant_reg;
        tx1_ready    = grant_reg;
        rr_ptr_next  = ~grant_reg;
        pending_next = 1'b0;
        state_next   = RX_POLL;
      end

      default: state_next = RX_POLL;
    endcase

    if (reset) begin
      nicEn     = 1'b0;
      nicWrEn   = 1'b0;
      nicAddr   = ADDR_RX_DATA;
      nicDin    = '0;
      rx_data   = '0;
      rx0_valid = 1'b0;
      rx1_valid = 1'b0;
      tx0_ready = 1'b0;
      tx1_ready = 1'b0;
    end
  end

endmodule

// File: tb/tb_nic_access_scheduler.sv
// Bench for nic_access_scheduler: a behavioural NIC (receive FIFO, bounded
// output buffer), randomized clients, and a scoreboard monitor that checks
// deliveries, writes, round-robin order and port protocol.
module tb_nic_access_scheduler;

  logic        clk;
  logic        reset;
  logic        tx0_valid, tx1_valid, tx0_ready, tx1_ready;
  logic [63:0] tx0_data, tx1_data;
  logic [63:0] rx_data;
  logic        rx0_valid, rx1_valid, rx0_ready, rx1_ready;
  logic        nicEn, nicWrEn;
  logic [1:0]  nicAddr;
  logic [63:0] nicDin, nicDout;

  nic_access_scheduler #(.DATA_WIDTH(64), .RX_SEL_BIT(56)) dut (
    .clk(clk), .reset(reset),
    .tx0_valid(tx0_valid), .tx0_data(tx0_data), .tx0_ready(tx0_ready),
    .tx1_valid(tx1_valid), .tx1_data(tx1_data), .tx1_ready(tx1_ready),
    .rx_data(rx_data),
    .rx0_valid(rx0_valid), .rx0_ready(rx0_ready),
    .rx1_valid(rx1_valid), .rx1_ready(rx1_ready),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .nicAddr(nicAddr),
    .nicDin(nicDin), .nicDout(nicDout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // stimulus / scoreboard state
  logic [63:0] txq    [2][$];   // flits each client still has to offer
  logic [63:0] exp_tx [2][$];   // flits offered and not yet seen written
  logic [63:0] exp_rx [$];      // flits read from the NIC, awaiting delivery
  logic [63:0] inj_q  [$];      // flits to drop into the NIC receive FIFO
  logic [63:0] rx_fifo[$];      // NIC receive FIFO
  logic        tx_valid_v[2];
  logic [63:0] tx_data_v [2];
  logic        sent_flag [2];
  int          gap_max = 0;
  int          rdy_pct = 100;
  int          inject_pct = 0;
  int          inj_left = 0;
  int          drain_pct = 100;
  int          out_cap = 4;
  int          out_cnt = 0;
  logic        force_full = 1'b0;
  logic        out_full;
  logic [63:0] rx_head = 64'h0;
  logic        rx_nonempty = 1'b0;
  int          write_count = 0;
  int          rx_deliv = 0;
  logic        last_write_client = 1'b0;

  assign tx0_valid = tx_valid_v[0];
  assign tx1_valid = tx_valid_v[1];
  assign tx0_data  = tx_data_v[0];
  assign tx1_data  = tx_data_v[1];
  assign out_full  = force_full || (out_cnt >= out_cap);
  assign nicDout   = !nicEn ? 64'h0 :
                     (nicAddr == 2'b00) ? rx_head :
                     (nicAddr == 2'b01) ? {63'h0, rx_nonempty} :
                     (nicAddr == 2'b11) ? {63'h0, out_full} : 64'h0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
  endtask

  // behavioural NIC: commit each access on the clock edge that ends it
  initial begin
    logic       en, we, rst, full_now;
    logic [1:0] a;
    forever begin
      @(negedge clk);
      en = nicEn; we = nicWrEn; a = nicAddr; rst = reset; full_now = out_full;
      if (en && we) chk("write_when_full", full_now, 1'b0);
      @(posedge clk);
      #1;
      if (rst) exp_rx.delete();
      if (en && !we && a == 2'b00) begin
        if (rx_fifo.size() == 0) fail_now("rx_read_empty");
        else exp_rx.push_back(rx_fifo.pop_front());
      end
      if (en && we) out_cnt++;
      if (out_cnt > 0 && $urandom_range(0, 99) < drain_pct) out_cnt--;
      if (inj_left > 0 && $urandom_range(0, 99) < inject_pct) begin
        inj_q.push_back({$urandom, $urandom});
        inj_left--;
      end
      while (inj_q.size() > 0) rx_fifo.push_back(inj_q.pop_front());
      rx_nonempty = (rx_fifo.size() > 0);
      rx_head     = rx_nonempty ? rx_fifo[0] : 64'h0;
    end
  end

  // receive-side client acceptance
  initial begin
    rx0_ready = 1'b0;
    rx1_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rx0_ready = ($urandom_range(0, 99) < rdy_pct);
      rx1_ready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // send-side client: offer queued flits in order, hold each until its ready pulse
  task automatic drive_client(input int c);
    int gap = 0;
    int waited = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_valid_v[c] && sent_flag[c]) begin
        tx_valid_v[c] = 1'b0;
        sent_flag[c]  = 1'b0;
      end
      if (tx_valid_v[c]) begin
        waited++;
        if (waited > 4000) begin
          fail_now("tx_timeout");
          tx_valid_v[c] = 1'b0;
          void'(exp_tx[c].pop_back());
        end
      end else if (gap > 0) begin
        gap--;
      end else if (txq[c].size() > 0) begin
        tx_data_v[c] = txq[c].pop_front();
        exp_tx[c].push_back(tx_data_v[c]);
        tx_valid_v[c] = 1'b1;
        waited = 0;
        gap = int'($urandom_range(0, gap_max));
      end
    end
  endtask

  initial begin
    tx_valid_v[0] = 1'b0; tx_valid_v[1] = 1'b0;
    tx_data_v[0] = 64'h0; tx_data_v[1] = 64'h0;
    sent_flag[0] = 1'b0; sent_flag[1] = 1'b0;
    fork
      drive_client(0);
      drive_client(1);
    join_none
  end

  // monitor: scoreboard pops and protocol checks, sampled mid-cycle
  initial begin
    logic         fair_last = 1'b1;
    logic         fair_flag = 1'b1;
    logic         flag_now, other, wr, c;
    logic         prev_hold = 1'b0;
    logic         prev_txpoll = 1'b0;
    logic [65:0]  prev_word = '0;
    logic [63:0]  e;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("reset_outputs",
            {nicEn, nicWrEn, nicAddr, rx0_valid, rx1_valid, tx0_ready, tx1_ready,
             (nicDin != 64'h0), (rx_data != 64'h0)}, '0);
        fair_last = 1'b1; fair_flag = 1'b1;
        prev_hold = 1'b0; prev_txpoll = 1'b0;
      end else begin
        wr = nicEn && nicWrEn;
        if (rx0_valid || rx1_valid) begin
          chk("rx_valid_onehot", rx0_valid & rx1_valid, 1'b0);
          chk("rx_no_nic_access", nicEn, 1'b0);
        end
        if (prev_hold) chk("rx_held_stable", {rx1_valid, rx0_valid, rx_data}, prev_word);
        if ((rx0_valid && rx0_ready) || (rx1_valid && rx1_ready)) begin
          if (exp_rx.size() == 0) fail_now("rx_unexpected_flit");
          else begin
            e = exp_rx.pop_front();
            chk("rx_data", rx_data, e);
            chk("rx_client", rx1_valid, e[56]);
            rx_deliv++;
          end
        end
        prev_hold = (rx0_valid && !rx0_ready) || (rx1_valid && !rx1_ready);
        prev_word = {rx1_valid, rx0_valid, rx_data};

        if (tx0_ready || tx1_ready) chk("ready_only_on_write", wr, 1'b1);
        other    = ~fair_last;
        flag_now = fair_flag && (other ? tx1_valid : tx0_valid);
        if (wr) begin
          chk("write_addr", nicAddr, 2'b10);
          chk("write_after_status_poll", prev_txpoll, 1'b1);
          chk("ready_onehot", tx0_ready ^ tx1_ready, 1'b1);
          if (tx0_ready ^ tx1_ready) begin
            c = tx1_ready;
            if (exp_tx[c].size() == 0) fail_now("tx_unexpected_write");
            else begin
              e = exp_tx[c].pop_front();
              chk("tx_data", nicDin, e);
            end
            if (flag_now) chk("rr_order", c, other);
            fair_last = c;
            fair_flag = 1'b1;
            sent_flag[c] = 1'b1;
            last_write_client = c;
            write_count++;
          end
        end else begin
          fair_flag = flag_now;
        end
        prev_txpoll = nicEn && !nicWrEn && (nicAddr == 2'b11);
      end
    end
  end

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (n < budget &&
           !(txq[0].size() == 0 && txq[1].size() == 0 && !tx_valid_v[0] && !tx_valid_v[1] &&
             exp_rx.size() == 0 && rx_fifo.size() == 0 && inj_q.size() == 0 && inj_left == 0)) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= budget) fail_now(name);
  endtask

  initial begin
    int          n, wc0, dc0;
    logic [63:0] flit;
    reset = 1'b1;

    // 1: reset, then an idle in_status poll every second cycle
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("idle_poll_en", nicEn, (i % 2 == 0));
      if (i % 2 == 0) chk("idle_poll_addr", {nicWrEn, nicAddr}, 3'b001);
    end
    @(posedge clk);
    #1;

    // 2: one flit for client 1, held while it is not ready
    rdy_pct = 0;
    dc0 = rx_deliv;
    inj_q.push_back(64'h0100_0000_0000_00AB);
    n = 0;
    do begin @(negedge clk); n++; end while (!rx1_valid && n < 20);
    chk("rx1_valid_seen", rx1_valid, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("rx1_wait", {rx1_valid, rx0_valid, nicEn, rx_data}, {3'b100, 64'h0100_0000_0000_00AB});
    end
    @(posedge clk);
    #1;
    rdy_pct = 100;
    wait_idle(50, "rx_deliver_timeout");
    chk("rx_delivered_count", rx_deliv - dc0, 1);

    // 3: single send from client 0
    wc0 = write_count;
    txq[0].push_back(64'hDEAD_BEEF_0000_0001);
    wait_idle(50, "tx0_send_timeout");
    chk("tx0_write_count", write_count - wc0, 1);
    chk("tx0_writer", last_write_client, 1'b0);

    // 4: both clients saturated with a free NIC -> strict alternation
    wc0 = write_count;
    for (int i = 0; i < 4; i++) begin
      txq[0].push_back({$urandom, $urandom});
      txq[1].push_back({$urandom, $urandom});
    end
    wait_idle(200, "alternate_timeout");
    chk("alternate_write_count", write_count - wc0, 8);

    // 6: reset while a flit waits for client 0
    rdy_pct = 0;
    flit = {$urandom, $urandom};
    flit[56] = 1'b0;
    inj_q.push_back(flit);
    n = 0;
    do begin @(negedge clk); n++; end while (!rx0_valid && n < 20);
    chk("rx0_valid_seen", rx0_valid, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    force_full = 1'b1;
    @(negedge clk);
    chk("reset_drops_rx0_valid", {rx0_valid, nicEn}, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rdy_pct = 100;
    @(negedge clk);
    chk("first_cycle_rx_poll", {nicEn, nicWrEn, nicAddr}, 4'b1001);

    // 5: output buffer full while client 0 holds the grant
    @(posedge clk);
    #1;
    wc0 = write_count;
    dc0 = rx_deliv;
    txq[0].push_back({$urandom, $urandom});
    repeat (3) @(posedge clk);
    #1;
    txq[1].push_back({$urandom, $urandom});
    flit = {$urandom, $urandom};
    flit[56] = 1'b1;
    inj_q.push_back(flit);
    repeat (30) @(posedge clk);
    #1;
    chk("no_write_while_full", write_count - wc0, 0);
    chk("rx_while_tx_blocked", rx_deliv - dc0, 1);
    force_full = 1'b0;
    n = 0;
    while (write_count == wc0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("first_write_after_full", {(write_count != wc0), last_write_client}, 2'b10);
    wait_idle(200, "full_release_timeout");

    // randomized traffic on both directions
    gap_max = 3; rdy_pct = 60; drain_pct = 30; out_cap = 2;
    inject_pct = 8; inj_left = 40;
    for (int i = 0; i < 30; i++) begin
      txq[0].push_back({$urandom, $urandom});
      txq[1].push_back({$urandom, $urandom});
    end
    wait_idle(20000, "random_phase_timeout");
    chk("tx_scoreboard_empty", exp_tx[0].size() + exp_tx[1].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
